// File: rtl/qspi_psram_model_p.sv
// rtl/qspi_psram_model_p.sv - behavioural QSPI/QPI PSRAM slave sampled on a fast clk
// Supports EBh quad read, 38h quad write, 66h/99h reset and 35h/F5h QPI enter/exit.
module qspi_psram_model_p #(
  parameter int ADR_BITS = 16,
  parameter int WAIT_CYC = 6,
  parameter bit QPI_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe
);

  typedef enum logic [2:0] {IDLE, CMD, ADR, WAIT, RDAT, WDAT, IGNORE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);

  logic                sck_q;
  logic                ce_n_q;
  logic [3:0]          sio_q;
  state_t              state;
  state_t              state_d;
  logic                qpi;
  logic                rst_en;
  logic                armed;
  logic                half;
  logic                is_read;
  logic [7:0]          cmd_sr;
  logic [7:0]          cnt;
  logic [3:0]          hi_nib;
  logic [ADR_BITS-1:0] addr;
  logic [7:0]          mem [0:(1<<ADR_BITS)-1];

  logic       rise;
  logic       fall;
  logic [7:0] cmd_next;
  logic       cmd_done;
  logic       adr_done;
  logic       wait_done;
  logic       mem_we;
  logic       tr_end;
  logic [7:0] rd_byte;

  assign rise      = sck & ~sck_q;
  assign fall      = ~sck & sck_q;
  assign cmd_next  = qpi ? {cmd_sr[3:0], sio_q} : {cmd_sr[6:0], sio_q[0]};
  assign cmd_done  = rise && (cnt == (qpi ? 8'd1 : 8'd7));
  assign adr_done  = rise && (cnt == 8'd5);
  assign wait_done = rise && (cnt == WAIT_LAST);
  assign mem_we    = (state == WDAT) && !ce_n_q && rise && half;
  assign rd_byte   = mem[addr];
  assign sio_oe    = (state == RDAT) && !ce_n_q;

  // Only transactions that got past command and address count as complete;
  // aborts in CMD/ADR leave mode and reset-enable untouched.
  assign tr_end = ce_n_q && (state inside {WAIT, RDAT, WDAT, IGNORE});

  always_comb begin
    state_d = state;
    if (ce_n_q) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (armed) state_d = CMD;
        CMD:     if (cmd_done)
                   state_d = (cmd_next == 8'hEB || cmd_next == 8'h38) ? ADR : IGNORE;
        ADR:     if (adr_done)
                   state_d = !is_read ? WDAT : ((WAIT_CYC == 0) ? RDAT : WAIT);
        WAIT:    if (wait_done) state_d = RDAT;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      sio_q   <= 4'h0;
      state   <= IDLE;
      qpi     <= 1'b0;
      rst_en  <= 1'b0;
      armed   <= 1'b0;
      half    <= 1'b0;
      is_read <= 1'b0;
      cmd_sr  <= 8'h00;
      cnt     <= 8'h00;
      hi_nib  <= 4'h0;
      addr    <= '0;
      sio_o   <= 4'h0;
    end else begin
      sck_q  <= sck;
      ce_n_q <= ce_n;
      sio_q  <= sio_i;
      state  <= state_d;
      // After reset a transaction already in flight must not be picked up mid-way.
      if (ce_n_q && ce_n) armed <= 1'b1;
      if (tr_end) begin
        rst_en <= (cmd_sr == 8'h66);
        if (QPI_EN && cmd_sr == 8'h35) qpi <= 1'b1;
        if (QPI_EN && cmd_sr == 8'hF5) qpi <= 1'b0;
      end
      if (!ce_n_q) begin
        case (state)
          IDLE: begin
            cnt  <= 8'h00;
            half <= 1'b0;
          end
          CMD: if (rise) begin
            cmd_sr <= cmd_next;
            cnt    <= cnt + 8'd1;
            if (cmd_done) begin
              cnt     <= 8'h00;
              is_read <= (cmd_next == 8'hEB);
              if (cmd_next == 8'h99 && rst_en) qpi <= 1'b0;
            end
          end
          ADR: if (rise) begin
            addr <= ADR_BITS'({addr, sio_q});
            cnt  <= adr_done ? 8'h00 : cnt + 8'd1;
          end
          WAIT: if (rise) cnt <= cnt + 8'd1;
          RDAT: if (fall) begin
            half  <= ~half;
            sio_o <= half ? rd_byte[3:0] : rd_byte[7:4];
            if (half) addr <= addr + 1'b1;
          end
          WDAT: if (rise) begin
            half <= ~half;
            if (!half) hi_nib <= sio_q;
            else       addr   <= addr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= {hi_nib, sio_q};
  end

endmodule

// File: tb/tb_qspi_psram_model_p.sv
// tb/tb_qspi_psram_model_p.sv - directed self-checking bench for qspi_psram_model_p
module tb_qspi_psram_model_p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       ce_n = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       sio_oe;

  int checks = 0;
  int errors = 0;
  logic oe_seen;

  qspi_psram_model_p #(.ADR_BITS(16), .WAIT_CYC(6), .QPI_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ce_n(ce_n),
    .sio_i(sio_i), .sio_o(sio_o), .sio_oe(sio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clock_nib(input logic [3:0] n);
    sio_i = n;
    #50 sck = 1'b1;
    #50 sck = 1'b0;
  endtask

  task automatic start_tr();
    ce_n = 1'b0;
    #50;
  endtask

  task automatic stop_tr();
    #50 ce_n = 1'b1;
    #100;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic q);
    if (q) begin
      clock_nib(b[7:4]);
      clock_nib(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) clock_nib({3'b000, b[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) clock_nib(a[i*4 +: 4]);
  endtask

  task automatic cmd_only(input logic [7:0] c, input logic q);
    start_tr();
    send_byte(c, q);
    stop_tr();
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    start_tr();
    send_byte(8'h38, 1'b0);
    send_addr(a);
    clock_nib(b0[7:4]); clock_nib(b0[3:0]);
    clock_nib(b1[7:4]); clock_nib(b1[3:0]);
    stop_tr();
  endtask

  // Leaves sck low just after the last dummy's falling edge, first nibble valid.
  task automatic read_start(input logic [23:0] a, input logic q);
    start_tr();
    send_byte(8'hEB, q);
    send_addr(a);
    for (int i = 0; i < 6; i++) clock_nib(4'h0);
    #50;
  endtask

  task automatic chk_nib(input string tag, input logic [3:0] exp);
    chk({tag, "_oe"}, {7'd0, sio_oe}, 8'h01);
    chk(tag, {4'h0, sio_o}, {4'h0, exp});
    sck = 1'b1;
    #50 sck = 1'b0;
    #50;
  endtask

  initial begin
    #23;
    chk("reset_oe", {7'd0, sio_oe}, 8'h00);
    chk("reset_o", {4'h0, sio_o}, 8'h00);
    #7 rst_n = 1'b1;
    #100;

    write_bytes(24'h000010, 8'hA5, 8'h3C);
    read_start(24'h000010, 1'b0);
    chk_nib("rd10_0", 4'hA);
    chk_nib("rd10_1", 4'h5);
    chk_nib("rd10_2", 4'h3);
    chk_nib("rd10_3", 4'hC);
    stop_tr();
    chk("idle_oe", {7'd0, sio_oe}, 8'h00);

    write_bytes(24'h00FFFF, 8'h11, 8'h22);
    read_start(24'h00FFFF, 1'b0);
    chk_nib("wrap_0", 4'h1);
    chk_nib("wrap_1", 4'h1);
    chk_nib("wrap_2", 4'h2);
    chk_nib("wrap_3", 4'h2);
    stop_tr();
    read_start(24'h000000, 1'b0);
    chk_nib("at0_0", 4'h2);
    chk_nib("at0_1", 4'h2);
    stop_tr();

    write_bytes(24'h000020, 8'h11, 8'hEE);
    start_tr();
    send_byte(8'h38, 1'b0);
    send_addr(24'h000020);
    clock_nib(4'h7); clock_nib(4'h8); clock_nib(4'h9);
    stop_tr();
    read_start(24'h000020, 1'b0);
    chk_nib("odd_0", 4'h7);
    chk_nib("odd_1", 4'h8);
    chk_nib("odd_2", 4'hE);
    chk_nib("odd_3", 4'hE);
    stop_tr();

    oe_seen = 1'b0;
    start_tr();
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 12; i++) begin
      oe_seen |= sio_oe;
      clock_nib(4'hF);
      oe_seen |= sio_oe;
    end
    stop_tr();
    chk("unk_oe", {7'd0, oe_seen}, 8'h00);
    read_start(24'h000010, 1'b0);
    chk_nib("unk_rd0", 4'hA);
    chk_nib("unk_rd1", 4'h5);
    stop_tr();

    cmd_only(8'h35, 1'b0);
    read_start(24'h000011, 1'b1);
    chk_nib("qpi_0", 4'h3);
    chk_nib("qpi_1", 4'hC);
    stop_tr();

    cmd_only(8'h99, 1'b1);
    read_start(24'h000010, 1'b1);
    chk_nib("keep_qpi_0", 4'hA);
    chk_nib("keep_qpi_1", 4'h5);
    stop_tr();

    cmd_only(8'h66, 1'b1);
    cmd_only(8'h99, 1'b1);
    read_start(24'h000010, 1'b0);
    chk_nib("spi_back_0", 4'hA);
    chk_nib("spi_back_1", 4'h5);
    stop_tr();

    read_start(24'h000010, 1'b0);
    chk_nib("pre_rst", 4'hA);
    rst_n = 1'b0;
    #3;
    chk("rst_oe", {7'd0, sio_oe}, 8'h00);
    chk("rst_o", {4'h0, sio_o}, 8'h00);
    #7 rst_n = 1'b1;
    oe_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clock_nib(4'h0);
      oe_seen |= sio_oe;
    end
    chk("post_rst_oe", {7'd0, oe_seen}, 8'h00);
    stop_tr();
    read_start(24'h000010, 1'b0);
    chk_nib("after_rst_0", 4'hA);
    chk_nib("after_rst_1", 4'h5);
    chk_nib("after_rst_2", 4'h3);
    chk_nib("after_rst_3", 4'hC);
    stop_tr();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_psram_model_p.md
QSPI_PSRAM_MODEL_P -- requirements
Module: qspi_psram_model_p

Interface
REQ-001 SHALL have parameter ADR_BITS, default 16, meaning byte-address width of internal memory (depth 2^ADR_BITS bytes).
REQ-002 SHALL have parameter WAIT_CYC, default 6, meaning dummy SCK cycles between address and first read nibble.
REQ-003 SHALL have parameter QPI_EN, default 1, meaning QPI-mode commands 35h/F5h are honoured (0: treated as unknown).
REQ-004 SHALL have port: clk  input  1  simulation sampling clock.
REQ-005 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port: sck  input  1  serial clock, mode 0, slower than clk/4.
REQ-007 SHALL have port: ce_n  input  1  chip enable, active low.
REQ-008 SHALL have port: sio_i  input  4  serial data in.
REQ-009 SHALL have port: sio_o  output  4  serial data out.
REQ-010 SHALL have port: sio_oe  output  1  drive enable for sio_o.

Function
REQ-011 SHALL register sck, ce_n, sio_i once in clk; rise = sck & ~sck_q, fall = ~sck & sck_q; all state changes only on clk edges.
REQ-012 SHALL sample input bits/nibbles from registered sio_i on each detected rise.
REQ-013 SHALL implement states IDLE, CMD, ADR, WAIT, RDAT, WDAT, IGNORE; registered ce_n high forces IDLE on the next clk from any state.
REQ-014 IDLE->CMD on registered ce_n low; command = 8 rises on sio_i[0] MSB first (SPI mode) or 2 rises, high nibble first (QPI mode).
REQ-015 Commands: EBh quad read, 38h quad write -> ADR; 66h reset-enable, 99h reset, 35h enter QPI, F5h exit QPI -> IGNORE after decode; others -> IGNORE.
REQ-016 ADR SHALL take 6 nibble rises MSB first forming 24-bit address; only low ADR_BITS used.
REQ-017 EBh: ADR->WAIT for exactly WAIT_CYC rises, then RDAT; 38h: ADR->WDAT directly.
REQ-018 RDAT: on each fall drive next nibble, high nibble of current byte first; first fall after last dummy rise drives high nibble of byte[addr].
REQ-019 sio_oe SHALL be 1 only in RDAT with ce_n low; sio_o SHALL hold last driven nibble otherwise.
REQ-020 WDAT: nibble pairs high-then-low; byte written to memory on low-nibble rise; odd trailing nibble at ce_n rise SHALL be discarded.
REQ-021 Byte address SHALL increment after each full byte and wrap from 2^ADR_BITS-1 to 0.
REQ-022 99h SHALL take effect only if immediately previous transaction was exactly 66h; effect: QPI mode cleared, state IDLE; memory contents unchanged.
REQ-023 35h/F5h SHALL set/clear QPI mode at ce_n rise ending that transaction; takes effect next transaction.
REQ-024 Any non-66h transaction SHALL clear the reset-enable flag; ce_n high mid-command or mid-address aborts without side effects.

Reset
REQ-025 On rst_n low: state IDLE, QPI mode 0, reset-enable 0, sio_oe 0, sio_o 4'h0, synchronisers sck_q 0, ce_n_q 1; memory not initialised by reset.
REQ-026 rst_n asserted mid-transaction SHALL abort immediately; after release, transaction resumes only after ce_n high then low.

Verification
REQ-027 SPI 38h, addr 000010h, data A5h 3Ch -> bytes 0010h=A5h, 0011h=3Ch; then EBh addr 000010h, 6 dummies -> sio_o nibbles A,5,3,C with sio_oe 1.
REQ-028 Write at FFFFh bytes 11h 22h (ADR_BITS 16) -> 22h stored at 0000h; read from FFFFh returns 11h then 22h.
REQ-029 Write 3 nibbles 7,8,9 at 0020h -> 0020h=78h, 0021h unchanged.
REQ-030 35h then QPI-mode 2-nibble EBh read -> correct data; 66h,99h -> next SPI-mode EBh works; 99h without preceding 66h -> QPI mode retained.
REQ-031 Unknown command 05h -> sio_oe stays 0 for whole transaction, memory unchanged; next transaction decodes normally.
REQ-032 rst_n pulsed low during RDAT -> sio_oe 0 within one clk, memory intact, following read returns prior data.
